// File: rtl/aes_axis_slave_pkg.sv
// Shared widths and the ingress FSM encoding for the AES AXI-Stream slave.
package aes_axis_slave_pkg;
   localparam int WORD_S = 32;   // AXI-Stream beat width
   localparam int BLK_S  = 128;  // AES block / input FIFO entry width

   typedef enum logic [1:0] {
      S_CMD   = 2'd0,  // waiting for the command word
      S_DATA  = 2'd1,  // packing payload words into blocks
      S_FLUSH = 2'd2,  // last block loaded, waiting for it to leave
      S_DONE  = 2'd3   // packet handed off, waiting for the controller
   } state_t;
endpackage

// File: rtl/aes_axis_slave_if.sv
// Stream-in and FIFO-out handshake bundle for the AES ingress stage.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready; valid, once raised, holds with stable data until
// that transfer, and valid never waits on ready.
interface aes_axis_slave_if
   import aes_axis_slave_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = WORD_S,
   parameter int BLK_WIDTH       = BLK_S
) ();
   logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata;
   logic                       s_axis_tvalid;
   logic                       s_axis_tlast;
   logic                       s_axis_tready;
   logic                       in_fifo_write_tvalid;
   logic                       in_fifo_write_tready;
   logic [BLK_WIDTH-1:0]       in_fifo_data;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      output s_axis_tready,
      output in_fifo_write_tvalid, in_fifo_data,
      input  in_fifo_write_tready
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready,
      input  in_fifo_write_tvalid, in_fifo_data,
      output in_fifo_write_tready
   );
endinterface

// File: rtl/aes_axis_slave_axis_word_packer.sv
// Packs stream words MSW-first into blocks and holds each finished block
// for the FIFO. A short final block is zero-padded in its low words.
module axis_word_packer #(
   parameter int AXIS_DATA_WIDTH = 32,
   parameter int BLK_WIDTH       = 128
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clr,
   input  logic                       beat_acc,
   input  logic [AXIS_DATA_WIDTH-1:0] beat_data,
   input  logic                       beat_last,
   input  logic                       push_ready,
   output logic                       blk_valid,
   output logic [BLK_WIDTH-1:0]       blk_data,
   output logic                       blk_full,
   output logic                       blk_stall
);
   localparam int N  = BLK_WIDTH / AXIS_DATA_WIDTH;
   localparam int CW = $clog2(N);

   logic [CW-1:0]        cnt;
   logic [BLK_WIDTH-1:0] gather;
   logic [BLK_WIDTH-1:0] next_gather;
   logic                 load;
   logic                 push;

   // Gather contents with the current beat dropped into its slot.
   always_comb begin
      next_gather = gather;
      next_gather[BLK_WIDTH - AXIS_DATA_WIDTH * (int'(cnt) + 1) +: AXIS_DATA_WIDTH] = beat_data;
   end

   assign blk_full  = (cnt == CW'(N - 1));
   assign load      = beat_acc && (blk_full || beat_last);
   assign push      = blk_valid && push_ready;
   assign blk_stall = blk_valid && !push_ready;

   // Word counter and gather register; cleared after every block so a
   // short block arrives with zeros in its unfilled words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         gather <= '0;
      end else if (clr) begin
         cnt    <= '0;
         gather <= '0;
      end else if (beat_acc) begin
         if (load) begin
            cnt    <= '0;
            gather <= '0;
         end else begin
            cnt    <= cnt + CW'(1);
            gather <= next_gather;
         end
      end
   end

   // Holding register toward the FIFO; reloads in the same cycle it pushes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blk_valid <= 1'b0;
         blk_data  <= '0;
      end else if (load) begin
         blk_valid <= 1'b1;
         blk_data  <= next_gather;
      end else if (push) begin
         blk_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/aes_axis_slave.sv
// AES ingress stage: latches the command word of each packet, packs the
// payload into blocks for the input FIFO, then waits for the controller.
module aes_axis_slave
   import aes_axis_slave_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = WORD_S,
   parameter int BLK_WIDTH       = BLK_S
) (
   input  logic                       clk,
   input  logic                       reset,
   aes_axis_slave_if.slave            axis,
   output logic [AXIS_DATA_WIDTH-1:0] aes_cmd,
   output logic                       axis_slave_done,
   input  logic                       processing_done,
   output logic                       pkt_len_err,
   output state_t                     state_dbg
);
   state_t state;
   logic   run;        // low only in the first cycle after reset, keeps tready 0 in reset
   logic   tready_c;
   logic   beat_any;
   logic   beat_data;
   logic   blk_full;
   logic   blk_stall;
   logic   clr;

   assign beat_any  = axis.s_axis_tvalid && tready_c;
   assign beat_data = beat_any && (state == S_DATA);
   assign clr       = (state == S_DONE) && processing_done;
   assign state_dbg = state;
   assign axis.s_axis_tready = tready_c;

   // Stream ready: stall only when a block-completing beat (4th word or a
   // short tlast) would have to load a holding register that cannot drain.
   always_comb begin
      tready_c = 1'b0;
      case (state)
         S_CMD:   tready_c = run;
         S_DATA:  tready_c = !(blk_stall && (blk_full || axis.s_axis_tlast));
         default: tready_c = 1'b0;
      endcase
   end

   axis_word_packer #(
      .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
      .BLK_WIDTH       (BLK_WIDTH)
   ) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clr        (clr),
      .beat_acc   (beat_data),
      .beat_data  (axis.s_axis_tdata),
      .beat_last  (axis.s_axis_tlast),
      .push_ready (axis.in_fifo_write_tready),
      .blk_valid  (axis.in_fifo_write_tvalid),
      .blk_data   (axis.in_fifo_data),
      .blk_full   (blk_full),
      .blk_stall  (blk_stall)
   );

   // Packet-level FSM with registered command, done and length-error outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_CMD;
         run             <= 1'b0;
         aes_cmd         <= '0;
         axis_slave_done <= 1'b0;
         pkt_len_err     <= 1'b0;
      end else begin
         run <= 1'b1;
         case (state)
            S_CMD: begin
               if (beat_any) begin
                  aes_cmd     <= axis.s_axis_tdata;
                  pkt_len_err <= 1'b0;
                  if (axis.s_axis_tlast) begin
                     axis_slave_done <= 1'b1;
                     state           <= S_DONE;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (beat_data && axis.s_axis_tlast) begin
                  if (!blk_full) pkt_len_err <= 1'b1;
                  state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (!axis.in_fifo_write_tvalid) begin
                  axis_slave_done <= 1'b1;
                  state           <= S_DONE;
               end
            end
            S_DONE: begin
               if (processing_done) begin
                  axis_slave_done <= 1'b0;
                  state           <= S_CMD;
               end
            end
            default: state <= S_CMD;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_axis_slave.sv
// Directed bench for aes_axis_slave with a block scoreboard on the FIFO side.
module tb_aes_axis_slave;
   import aes_axis_slave_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_axis_slave_if bus ();
   logic [31:0] aes_cmd;
   logic        done;
   logic        processing_done;
   logic        err;
   state_t      state_dbg;

   aes_axis_slave dut (
      .clk             (clk),
      .reset           (rst_n),
      .axis            (bus),
      .aes_cmd         (aes_cmd),
      .axis_slave_done (done),
      .processing_done (processing_done),
      .pkt_len_err     (err),
      .state_dbg       (state_dbg)
   );

   // ---------------- bookkeeping ----------------
   int           total = 0;
   int           bad   = 0;
   logic [127:0] exp_q[$];
   int           push_cnt      = 0;
   int           cyc           = 0;
   int           last_push_cyc = 0;
   int           stall_req     = 0;
   bit           stall_arm     = 0;
   int           first_stall   = 0;
   int           beat_idx      = 0;
   int           done_cyc      = 0;
   int           push_before   = 0;
   logic [31:0]  payload[16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- FIFO ready driver ----------------
   // When armed, refuses the FIFO for 10 cycles starting as the first block appears.
   initial begin
      bus.in_fifo_write_tready = 1'b1;
      forever begin
         @(negedge clk);
         if (stall_arm && bus.in_fifo_write_tvalid) begin
            stall_req = 10;
            stall_arm = 0;
         end
         if (stall_req > 0) begin
            bus.in_fifo_write_tready = 1'b0;
            stall_req--;
         end else begin
            bus.in_fifo_write_tready = 1'b1;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.in_fifo_write_tvalid && bus.in_fifo_write_tready) begin
            push_cnt++;
            last_push_cyc = cyc + 1;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_push: got %h expected none", bus.in_fifo_data);
            end else begin
               check("fifo_block", bus.in_fifo_data, exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic send_beat(input logic [31:0] d, input bit l);
      int guard;
      beat_idx++;
      bus.s_axis_tdata  = d;
      bus.s_axis_tlast  = l;
      bus.s_axis_tvalid = 1'b1;
      #1;
      guard = 0;
      while (!bus.s_axis_tready && guard < 300) begin
         if (first_stall == 0 && beat_idx > 0) first_stall = beat_idx;
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 300) begin
         total++;
         bad++;
         $display("FAIL beat_timeout: got tready 0 expected 1 (beat %0d)", beat_idx);
      end
      @(negedge clk);
   endtask

   task automatic send_pkt(input logic [31:0] cmd, input int n);
      beat_idx    = -1;
      first_stall = 0;
      send_beat(cmd, n == 0);
      for (int i = 0; i < n; i++) send_beat(payload[i], i == n - 1);
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_done();
      int guard;
      guard = 0;
      #1;
      while (!done && guard < 300) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (guard >= 300) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got done 0 expected 1");
      end
      done_cyc = cyc;
   endtask

   task automatic release_pkt();
      @(negedge clk);
      processing_done = 1'b1;
      @(negedge clk);
      processing_done = 1'b0;
      #1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      bus.s_axis_tdata  = '0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      processing_done   = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_flags", {bus.s_axis_tready, bus.in_fifo_write_tvalid, done, err}, 4'b0000);
      check("reset_data", bus.in_fifo_data, 128'h0);
      check("reset_cmd", aes_cmd, 32'h0);
      check("reset_state", state_dbg, S_CMD);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: one full block, FIFO always ready
      payload[0] = 32'h00112233; payload[1] = 32'h44556677;
      payload[2] = 32'h8899AABB; payload[3] = 32'hCCDDEEFF;
      exp_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
      send_pkt(32'h0000_0025, 4);
      wait_done();
      check("t1_done_latency", done_cyc, last_push_cyc + 1);
      check("t1_cmd", aes_cmd, 32'h0000_0025);
      check("t1_len_err", err, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("t1_tready_held_low", bus.s_axis_tready, 1'b0);
      end
      check("t1_cmd_stable", aes_cmd, 32'h0000_0025);
      release_pkt();
      check("t1_done_cleared", done, 1'b0);
      check("t1_tready_back", bus.s_axis_tready, 1'b1);

      // T2: three back-to-back blocks, no stall expected
      payload[0]  = 32'h10000000; payload[1]  = 32'h10000001;
      payload[2]  = 32'h10000002; payload[3]  = 32'h10000003;
      payload[4]  = 32'h10000004; payload[5]  = 32'h10000005;
      payload[6]  = 32'h10000006; payload[7]  = 32'h10000007;
      payload[8]  = 32'h10000008; payload[9]  = 32'h10000009;
      payload[10] = 32'h1000000A; payload[11] = 32'h1000000B;
      exp_q.push_back(128'h10000000_10000001_10000002_10000003);
      exp_q.push_back(128'h10000004_10000005_10000006_10000007);
      exp_q.push_back(128'h10000008_10000009_1000000A_1000000B);
      @(negedge clk);
      send_pkt(32'h0000_0011, 12);
      check("t2_no_stall", first_stall, 0);
      wait_done();
      check("t2_len_err", err, 1'b0);
      release_pkt();

      // T3: same 12 beats, FIFO refuses 10 cycles once the first block appears
      exp_q.push_back(128'h10000000_10000001_10000002_10000003);
      exp_q.push_back(128'h10000004_10000005_10000006_10000007);
      exp_q.push_back(128'h10000008_10000009_1000000A_1000000B);
      stall_arm = 1;
      @(negedge clk);
      send_pkt(32'h0000_0012, 12);
      check("t3_first_stall_beat", first_stall, 8);
      wait_done();
      check("t3_cmd", aes_cmd, 32'h0000_0012);
      release_pkt();

      // T4: 6 payload words -> one full and one zero-padded block
      payload[0] = 32'hAAAA0001; payload[1] = 32'hBBBB0002;
      payload[2] = 32'hCCCC0003; payload[3] = 32'hDDDD0004;
      payload[4] = 32'hEEEE0005; payload[5] = 32'hFFFF0006;
      exp_q.push_back(128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004);
      exp_q.push_back(128'hEEEE0005_FFFF0006_00000000_00000000);
      @(negedge clk);
      send_pkt(32'h0000_0033, 6);
      wait_done();
      check("t4_len_err", err, 1'b1);
      check("t4_done", done, 1'b1);
      release_pkt();
      check("t4_len_err_sticky", err, 1'b1);

      // T5: command-only packet
      push_before = push_cnt;
      @(negedge clk);
      send_pkt(32'h0000_0077, 0);
      #1;
      check("t5_done_next_cycle", done, 1'b1);
      check("t5_cmd", aes_cmd, 32'h0000_0077);
      check("t5_len_err_cleared", err, 1'b0);
      repeat (3) @(negedge clk);
      check("t5_no_push", push_cnt, push_before);
      release_pkt();
      check("t5_done_cleared", done, 1'b0);
      check("t5_tready_back", bus.s_axis_tready, 1'b1);

      // T6: reset in the middle of a block, then a clean packet
      @(negedge clk);
      beat_idx = -1;
      send_beat(32'h0000_0099, 1'b0);
      send_beat(32'h12345678, 1'b0);
      send_beat(32'h9ABCDEF0, 1'b0);
      bus.s_axis_tvalid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("t6_reset_flags", {bus.s_axis_tready, bus.in_fifo_write_tvalid, done, err}, 4'b0000);
      check("t6_reset_data", bus.in_fifo_data, 128'h0);
      check("t6_reset_cmd", aes_cmd, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      payload[0] = 32'h01020304; payload[1] = 32'h05060708;
      payload[2] = 32'h090A0B0C; payload[3] = 32'h0D0E0F10;
      exp_q.push_back(128'h01020304_05060708_090A0B0C_0D0E0F10);
      send_pkt(32'h0000_005A, 4);
      wait_done();
      check("t6_cmd", aes_cmd, 32'h0000_005A);
      release_pkt();

      // final report
      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      check("push_count", push_cnt, 10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/aes_axis_slave.md
Name: aes_axis_slave

Overview:
- Upstream ingress stage for the AES controller.
- Accepts a 32-bit AXI-Stream packet from the DMA.
  - First word is the command word; it is latched and exported as aes_cmd.
  - Remaining words are packed four at a time into 128-bit blocks, which are written into the input FIFO that the controller drains.
- Signals end of packet with axis_slave_done. Holds off the next packet until the controller reports processing_done.

Parameters:
- AXIS_DATA_WIDTH, 32, AXI-Stream beat width; equals `WORD_S.
- BLK_WIDTH, 128, FIFO entry width; equals `BLK_S. Must be an integer multiple of AXIS_DATA_WIDTH.

Ports:
- clk  in  1  Single clock for all logic.
- reset  in  1  Asynchronous, active-low reset.
- s_axis_tdata  in  32  Stream data.
- s_axis_tvalid  in  1  Stream valid.
- s_axis_tlast  in  1  Last beat of packet.
- s_axis_tready  out  1  Stream ready.
- in_fifo_write_tvalid  out  1  Block valid toward input FIFO.
- in_fifo_write_tready  in  1  FIFO can accept a block.
- in_fifo_data  out  128  Packed block.
- aes_cmd  out  32  Latched command word of the current packet.
- axis_slave_done  out  1  Level: whole packet pushed into FIFO.
- processing_done  in  1  Controller finished the packet.
- pkt_len_err  out  1  Sticky: packet payload was not a multiple of 4 words.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0. State is S_CMD, word counter is 0, gather register is 0.
- Beat accepted when s_axis_tvalid && s_axis_tready. FIFO push occurs when in_fifo_write_tvalid && in_fifo_write_tready.
- State S_CMD:
  - tready = 1.
  - On a beat: aes_cmd <= tdata, pkt_len_err <= 0.
  - If tlast: go to S_DONE, since a command-only packet is legal (no blocks).
  - Else: go to S_DATA.
- State S_DATA, word packing:
  - The first payload beat of a block goes to gather[127:96], then [95:64], [63:32], [31:0].
  - A 2-bit counter wraps 3->0.
- Output holding register: the 4th beat transfers {gather, beat} into in_fifo_data and sets tvalid.
  - The transfer happens in the same cycle as the beat.
  - It is allowed only if the holding register is empty, or is being pushed in that same cycle.
- tready in S_DATA = !(counter == 3 && in_fifo_write_tvalid && !in_fifo_write_tready).
  - Result: zero-bubble throughput of one beat per cycle while the FIFO accepts.
  - Stalls only when a full block has nowhere to go.
- tlast in S_DATA:
  - If counter == 3: last block is loaded normally.
  - Else: the partial block is zero-padded in the unfilled low words, loaded into the holding register, and pkt_len_err <= 1.
  - Either case: go to S_FLUSH.
- State S_FLUSH: tready = 0. When the holding register is empty (last push done): axis_slave_done <= 1, go to S_DONE.
- State S_DONE:
  - tready = 0 and axis_slave_done = 1.
  - On processing_done = 1: axis_slave_done <= 0, counter <= 0, go to S_CMD.
  - aes_cmd is held stable through S_DONE and changes only on the next command beat.
- Entry to S_DONE from S_CMD (command-only packet) sets axis_slave_done <= 1 in the same cycle.
- in_fifo_write_tvalid, once high, stays high with stable data until the push occurs (AXIS rule).
- processing_done outside S_DONE is ignored.
- Reset mid-packet discards gather and holding contents. Upstream DMA must be restarted by software.

Decomposition:
- Shared package aes.vh supplies `WORD_S and `BLK_S and state encodings. Add S_CMD/S_DATA/S_FLUSH/S_DONE localparams there only if reused.
- One natural sub-module: axis_word_packer.
  - Contains the counter, gather register and holding register with its skid logic.
  - Parameterised by AXIS_DATA_WIDTH/BLK_WIDTH.
  - The top-level FSM wraps it.

Test Plan:
- Cmd 0x0000_0025 + 4 beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF (tlast on 5th), FIFO always ready -> one push of 0x00112233_44556677_8899AABB_CCDDEEFF; aes_cmd=0x25; done rises one cycle after the push; tready low until processing_done.
- Cmd + 12 payload beats, tvalid continuous, FIFO ready -> 3 pushes, tready never drops before tlast.
- Same 12 beats with in_fifo_write_tready held 0 for 10 cycles after the first block -> tready drops on the beat-8 slot; no data lost; blocks are pushed in order.
- Cmd + 6 payload beats A..F -> blocks {A,B,C,D} and {E,F,0,0}; pkt_len_err=1; done=1.
- Command-only packet (single beat with tlast) -> no push; done=1 next cycle; processing_done pulse -> done=0 and tready=1.
- Assert reset low mid-block (after 2 payload beats) -> all outputs 0 immediately; after release, a fresh cmd + 4-beat packet produces exactly one correct block.
